// File: rtl/kv_decompress.sv
// kv_decompress: read-path inverse of the KV-cache compressor.
// One compressed row (D signed delta codes plus an unsigned fixed-point scale)
// is accepted per AXI-Stream beat. The quantized values are rebuilt with a
// running prefix sum, LANES elements per cycle. Each value is dequantized
// with round-half-up and saturation, and the full row leaves as one beat.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   s_axis_tvalid/tready/tdata/tscale/tlast   compressed row input
//   m_axis_tvalid/tready/tdata/tlast          reconstructed row output
//   busy               high while a row is being decoded or held for output
//   row_count          rows emitted in the current frame (cleared after tlast)
module kv_decompress #(
  parameter int D       = 128,
  parameter int LANES   = 16,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 16,
  parameter int SCALE_W = 16,
  parameter int FRAC    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [IN_W*D-1:0]    s_axis_tdata,
  input  logic [SCALE_W-1:0]   s_axis_tscale,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OUT_W*D-1:0]   m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic [15:0]          row_count
);

  localparam int NCHUNK = D / LANES;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // Product width: signed code times zero-extended unsigned scale.
  localparam int PW     = IN_W + SCALE_W + 1;

  localparam logic [KW-1:0]        LAST_K  = KW'(NCHUNK - 1);
  localparam logic signed [PW-1:0] ROUND_C = PW'(2 ** (FRAC - 1));
  localparam logic signed [PW-1:0] Y_MAX   = PW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [PW-1:0] Y_MIN   = PW'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  state_t                state_r;
  logic [IN_W*D-1:0]     delta_r;
  logic [SCALE_W-1:0]    scale_r;
  logic                  last_r;
  logic [IN_W-1:0]       running_r;
  logic [KW-1:0]         k_r;
  logic                  tready_r;
  logic                  busy_r;
  logic                  tvalid_r;
  logic [OUT_W*D-1:0]    tdata_r;
  logic                  tlast_r;
  logic [15:0]           row_count_r;

  logic [IN_W-1:0]       acc_s;
  logic [OUT_W*LANES-1:0] y_chunk_s;
  logic [OUT_W*D-1:0]    next_row_s;

  // q * scale, add half an LSB, arithmetic shift (halves go toward +inf),
  // then clamp into the signed output range.
  function automatic logic [OUT_W-1:0] dequant(input logic [IN_W-1:0] q,
                                               input logic [SCALE_W-1:0] s);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    p = PW'($signed(q)) * PW'($signed({1'b0, s}));
    r = (p + ROUND_C) >>> FRAC;
    if (r > Y_MAX) begin
      dequant = Y_MAX[OUT_W-1:0];
    end else if (r < Y_MIN) begin
      dequant = Y_MIN[OUT_W-1:0];
    end else begin
      dequant = r[OUT_W-1:0];
    end
  endfunction

  // Prefix-sum the current chunk (always the low lanes of delta_r) with
  // mod-2^IN_W wrap and dequantize every lane.
  always_comb begin
    acc_s     = running_r;
    y_chunk_s = {(OUT_W*LANES){1'b0}};
    for (int j = 0; j < LANES; j++) begin
      acc_s = acc_s + delta_r[j*IN_W +: IN_W];
      y_chunk_s[j*OUT_W +: OUT_W] = dequant(acc_s, scale_r);
    end
  end

  // The output row is filled as a shift register: each chunk enters at the
  // top, so after NCHUNK chunks element 0 sits in the lowest lane.
  always_comb begin
    next_row_s = tdata_r >> (LANES * OUT_W);
    next_row_s[OUT_W*(D-LANES) +: OUT_W*LANES] = y_chunk_s;
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      delta_r     <= {(IN_W*D){1'b0}};
      scale_r     <= {SCALE_W{1'b0}};
      last_r      <= 1'b0;
      running_r   <= {IN_W{1'b0}};
      k_r         <= {KW{1'b0}};
      tready_r    <= 1'b1;
      busy_r      <= 1'b0;
      tvalid_r    <= 1'b0;
      tdata_r     <= {(OUT_W*D){1'b0}};
      tlast_r     <= 1'b0;
      row_count_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (s_axis_tvalid) begin
            delta_r   <= s_axis_tdata;
            scale_r   <= s_axis_tscale;
            last_r    <= s_axis_tlast;
            running_r <= {IN_W{1'b0}};
            k_r       <= {KW{1'b0}};
            tready_r  <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= ST_DECODE;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_DECODE: begin
          delta_r   <= delta_r >> (LANES * IN_W);
          tdata_r   <= next_row_s;
          running_r <= acc_s;
          k_r       <= k_r + KW'(1);
          if (k_r == LAST_K) begin
            state_r  <= ST_OUT;
            tvalid_r <= 1'b1;
            tlast_r  <= last_r;
          end else begin
            state_r  <= ST_DECODE;
          end
        end
        ST_OUT: begin
          if (m_axis_tready) begin
            tvalid_r    <= 1'b0;
            tready_r    <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
            row_count_r <= tlast_r ? 16'd0 : (row_count_r + 16'd1);
          end else begin
            state_r     <= ST_OUT;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tvalid_r <= 1'b0;
          tready_r <= 1'b1;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = tready_r;
  assign busy          = busy_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tlast  = tlast_r;
  assign row_count     = row_count_r;

endmodule

// File: tb/tb_kv_decompress.sv
// Self-checking bench for kv_decompress: table-driven rows checked through a
// scoreboard queue, plus hand-written back-pressure, frame and reset sequences.
module tb_kv_decompress;

  localparam int D  = 128;
  localparam int IW = 8;
  localparam int OW = 16;

  logic              clk;
  logic              rst_n;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [IW*D-1:0]   s_axis_tdata;
  logic [15:0]       s_axis_tscale;
  logic              s_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [OW*D-1:0]   m_axis_tdata;
  logic              m_axis_tlast;
  logic              busy;
  logic [15:0]       row_count;

  kv_decompress dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tscale (s_axis_tscale),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .row_count     (row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW*D-1:0] data;
    logic            last;
  } exp_t;

  typedef struct {
    int          pat;    // 0: all deltas = v, 1: only delta[0] = v, 2: random
    int          v;
    logic [15:0] scale;
    logic        last;
    logic        spot;   // check y[0] and y[D-1] against the constants below
    int          e0;
    int          elast;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        vecs[7];
  int          n_checks;
  int          n_fail;
  int          cyc;
  logic [15:0] rc_model;
  int          lat;
  int          acc_c[3];
  logic [OW*D-1:0] hold_d;
  logic            hold_l;
  logic [IW*D-1:0] d_tmp;
  logic [IW*D-1:0] d_two;
  logic            saw_valid;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [OW*D-1:0] act,
                         input logic [OW*D-1:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = D - 1; i >= 0; i--) begin
      if (act[i*OW +: OW] !== exp[i*OW +: OW]) bad = i;
    end
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: element %0d got %0d expected %0d", name, bad,
               $signed(act[bad*OW +: OW]), $signed(exp[bad*OW +: OW]));
    end
  endtask

  function automatic logic [IW*D-1:0] mk(input int pat, input int v);
    logic [IW*D-1:0] r;
    r = {(IW*D){1'b0}};
    for (int i = 0; i < D; i++) begin
      case (pat)
        0:       r[i*IW +: IW] = 8'(v);
        1:       if (i == 0) r[i*IW +: IW] = 8'(v);
        default: r[i*IW +: IW] = 8'($urandom_range(0, 255));
      endcase
    end
    return r;
  endfunction

  // Reference: integer running total, folded into the signed 8-bit range,
  // multiplied by the scale, floor((p + 128) / 256), then clamped.
  function automatic logic [OW*D-1:0] model_row(input logic [IW*D-1:0] d,
                                                input logic [15:0] s);
    logic [OW*D-1:0] r;
    int total, q, p, y;
    total = 0;
    for (int i = 0; i < D; i++) begin
      total = total + int'($signed(d[i*IW +: IW]));
      q = total & 255;
      if (q > 127) q = q - 256;
      p = q * int'(s);
      y = (p + 128) >>> 8;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      r[i*OW +: OW] = 16'(y);
    end
    return r;
  endfunction

  task automatic push_exp(input logic [IW*D-1:0] d, input logic [15:0] s,
                          input logic l);
    exp_t e;
    e.data = model_row(d, s);
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Present a row until accepted; afterwards scramble the inputs so any
  // late sampling shows up as corrupt output.
  task automatic send(input logic [IW*D-1:0] d, input logic [15:0] s,
                      input logic l, output int acc_cycle);
    int   n;
    logic took;
    n = 0;
    took = 1'b0;
    s_axis_tdata  = d;
    s_axis_tscale = s;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!took && n < 100) begin
      @(negedge clk);
      took = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = ~d;
    s_axis_tscale = ~s;
    s_axis_tlast  = ~l;
    acc_cycle = cyc;
    if (!took) chk("accept_timeout", 0, 1);
    else push_exp(d, s, l);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!m_axis_tvalid) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rc_model = 16'd0;
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = {(IW*D){1'b0}};
    s_axis_tscale = 16'd0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_row", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk_row("row_data", m_axis_tdata, mon_e.data);
            chk("row_tlast", m_axis_tlast, mon_e.last);
            chk("row_count_before", row_count, rc_model);
            rc_model = mon_e.last ? 16'd0 : (rc_model + 16'd1);
          end
        end
      end
    join_none

    vecs[0] = '{0,    1, 16'h0100, 1'b0, 1'b1,      1,   -128};
    vecs[1] = '{1,    1, 16'h0080, 1'b0, 1'b1,      1,      1};
    vecs[2] = '{1,   -1, 16'h0080, 1'b0, 1'b1,      0,      0};
    vecs[3] = '{0,    5, 16'h0000, 1'b0, 1'b1,      0,      0};
    vecs[4] = '{1, -128, 16'hFFFF, 1'b0, 1'b1, -32767, -32767};
    vecs[5] = '{1,  127, 16'hFFFF, 1'b0, 1'b1,  32512,  32512};
    vecs[6] = '{2,    0, 16'h0155, 1'b1, 1'b0,      0,      0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata_nonzero", (m_axis_tdata != {(OW*D){1'b0}}), 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row_count", row_count, 0);
    chk("rst_tready", s_axis_tready, 1);

    // Table-driven rows with output always ready.
    for (int v = 0; v < 7; v++) begin
      d_tmp = mk(vecs[v].pat, vecs[v].v);
      send(d_tmp, vecs[v].scale, vecs[v].last, acc_c[0]);
      chk("busy_after_accept", busy, 1);
      chk("tready_in_decode", s_axis_tready, 0);
      wait_valid(lat);
      chk("latency", lat, 8);
      if (vecs[v].spot) begin
        chk("spot_y0", $signed(m_axis_tdata[0 +: OW]), vecs[v].e0);
        chk("spot_ylast", $signed(m_axis_tdata[(D-1)*OW +: OW]), vecs[v].elast);
      end
      @(posedge clk);
      #1;
      chk("tvalid_drop", m_axis_tvalid, 0);
      chk("row_count_after", row_count, rc_model);
    end

    // Back-pressure: output held for several cycles, second row waiting.
    m_axis_tready = 1'b0;
    send(mk(2, 0), 16'h0233, 1'b0, acc_c[0]);
    wait_valid(lat);
    chk("bp_latency", lat, 8);
    hold_d = m_axis_tdata;
    hold_l = m_axis_tlast;
    d_two = mk(2, 0);
    s_axis_tdata  = d_two;
    s_axis_tscale = 16'h00C1;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_row("bp_data_hold", m_axis_tdata, hold_d);
      chk("bp_tlast_hold", m_axis_tlast, hold_l);
      chk("bp_tready_low", s_axis_tready, 0);
      chk("bp_tvalid_high", m_axis_tvalid, 1);
    end
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_after_hs_tvalid", m_axis_tvalid, 0);
    chk("bp_after_hs_busy", busy, 0);
    chk("bp_after_hs_tready", s_axis_tready, 1);
    @(posedge clk);
    #1;
    chk("bp_second_accept_busy", busy, 1);
    s_axis_tvalid = 1'b0;
    push_exp(d_two, 16'h00C1, 1'b1);
    wait_valid(lat);
    chk("bp2_latency", lat, 8);
    @(posedge clk);
    #1;
    chk("bp2_row_count", row_count, 0);

    // Frame of three rows, tlast on the third, ready held high.
    send(mk(2, 0), 16'h0100, 1'b0, acc_c[0]);
    send(mk(2, 0), 16'h0100, 1'b0, acc_c[1]);
    chk("frame_rc1", row_count, 1);
    send(mk(2, 0), 16'h0100, 1'b1, acc_c[2]);
    chk("frame_rc2", row_count, 2);
    chk("frame_spacing1", acc_c[1] - acc_c[0], 10);
    chk("frame_spacing2", acc_c[2] - acc_c[1], 10);
    wait_valid(lat);
    chk("frame_last_tlast", m_axis_tlast, 1);
    @(posedge clk);
    #1;
    chk("frame_rc_end", row_count, 0);

    // Reset in the middle of DECODE (k = 3) drops the row.
    send(mk(0, 3), 16'h0100, 1'b0, acc_c[0]);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    rc_model = 16'd0;
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tready", s_axis_tready, 1);
    saw_valid = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (m_axis_tvalid) saw_valid = 1'b1;
    end
    chk("midrst_no_output", saw_valid, 0);
    send(mk(0, 1), 16'h0100, 1'b0, acc_c[0]);
    wait_valid(lat);
    chk("postrst_latency", lat, 8);
    chk("postrst_y0", $signed(m_axis_tdata[0 +: OW]), 1);
    chk("postrst_y126", $signed(m_axis_tdata[126*OW +: OW]), 127);
    chk("postrst_y127", $signed(m_axis_tdata[127*OW +: OW]), -128);
    @(posedge clk);
    #1;
    chk("postrst_row_count", row_count, 1);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kv_decompress.md
Name: kv_decompress

Overview:
- Inverse of the KV-cache compression pipeline, on the read path from CXL memory back to the accelerator.
- Accepts one compressed row per AXI-Stream beat: D INT8 delta codes plus a per-row scale factor.
- Rebuilds the INT8 quantized values with a running prefix sum, processing LANES elements per cycle.
- Dequantizes with the fixed-point scale and emits one full row of signed 16-bit values per output beat.

Parameters:
D, 128, elements per row (hidden dim per head); must be a multiple of LANES
LANES, 16, elements decoded per cycle
IN_W, 8, delta code width (signed)
OUT_W, 16, reconstructed element width (signed)
SCALE_W, 16, scale width, unsigned fixed point
FRAC, 8, fractional bits of scale (0x0100 = 1.0)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
s_axis_tvalid  in  1  compressed row valid
s_axis_tready  out  1  block can accept a row
s_axis_tdata  in  IN_W*D  delta codes; element i at [i*IN_W +: IN_W]
s_axis_tscale  in  SCALE_W  row scale
s_axis_tlast  in  1  last row of frame
m_axis_tvalid  out  1  reconstructed row valid
m_axis_tready  in  1  downstream accepts
m_axis_tdata  out  OUT_W*D  reconstructed row; element i at [i*OUT_W +: OUT_W]
m_axis_tlast  out  1  registered copy of the accepted s_axis_tlast
busy  out  1  high in DECODE or OUT
row_count  out  16  rows emitted in the current frame

Behaviour:
- Reset is synchronous, active-low on rst_n; clock clk.
- Reset values: state=IDLE; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tlast=0; busy=0; row_count=0; internal running sum and chunk index = 0.
- A reset asserted mid-row discards that row; no partial output is produced.
- FSM states:
  - IDLE: s_axis_tready=1. On tvalid&&tready, register tdata, tscale and tlast, clear running sum (8-bit) and chunk index k, then go to DECODE.
  - DECODE: s_axis_tready=0. Each cycle, for j=0..LANES-1, q[kL+j] = running + sum of delta[kL..kL+j], all mod 2^8 with two's-complement wrap (no saturation). running <= q[kL+LANES-1]. Dequantized lanes are written into the output row register; k increments. After chunk D/LANES-1, go to OUT.
  - OUT: m_axis_tvalid=1; data and tlast hold stable until m_axis_tready. On handshake, go to IDLE and deassert m_axis_tvalid.
- Timing: for an input accepted at edge E0, DECODE occupies edges E1..E(D/LANES). m_axis_tvalid is high in the cycle after edge E(D/LANES), i.e. 8 cycles after acceptance at the defaults.
  - Sustained throughput: one row per D/LANES+2 cycles when m_axis_tready is held high.
  - No overlap between rows; s_axis_tready is low in DECODE and OUT.
- Dequantization per element:
  - p = signed(q) * unsigned(scale), 8x16 product, 25-bit signed.
  - y = (p + 2^(FRAC-1)) >>> FRAC, arithmetic shift, so halves round toward +inf.
  - Saturate y to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Scale 0 yields all-zero rows.
- row_count:
  - Increments on each output handshake.
  - On an output handshake with m_axis_tlast=1 it becomes 0 instead.
  - Wraps at 2^16.
- busy = (state != IDLE).
- s_axis_tdata, tscale and tlast are sampled only on the accept edge; changes in other cycles are ignored.

Test Plan:
- Wrap: scale=0x0100, all deltas=+1 -> y[i]=i+1 for i=0..126, y[127]=-128; m_axis_tvalid rises 8 cycles after accept; row_count goes 0->1 on the output handshake.
- Rounding, +0.5: scale=0x0080, delta[0]=+1, rest 0 -> every y=1 (128+128=256 >>8).
- Rounding, -0.5: scale=0x0080, delta[0]=-1, rest 0 -> every y=0 ((-128+128)>>8).
- Back-pressure: m_axis_tready low for 5 cycles in OUT -> tdata and tlast stable, s_axis_tready=0 throughout. A second s_axis_tvalid beat is not accepted until the cycle after the output handshake.
- Frame: 3 rows with tlast on row 3 and m_axis_tready=1 -> row_count 1, 2, then 0; m_axis_tlast=1 only on row 3; accepts spaced 10 cycles apart.
- Reset mid-DECODE: rst_n=0 for 1 cycle at k=3 -> m_axis_tvalid stays 0, busy=0, s_axis_tready=1. A new row then decodes correctly with the running sum starting at 0.
